fire_event_gateway_rx: RTL

- Gateway-side receiver for the fire-detection logic object's vote output (Output) and sensor vector (Flag[2:0]).
- Synchronises both inputs, confirms a fire event only after the vote holds for MIN_HOLD cycles, and flags single-sensor anomalies as sensor faults.
- Timestamps each event, queues it in a FIFO, and presents it to the uplink over a valid/ready stream.

---
 rtl/fire_gw_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fire_event_gateway_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fire_gw_pkg.sv
// rtl/fire_gw_pkg.sv - shared types and constants for the fire event gateway receiver
package fire_gw_pkg;

  localparam logic [1:0] FIRE   = 2'b01;
  localparam logic [1:0] FAULT  = 2'b10;
  localparam logic [1:0] GLITCH = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam int TEMP  = 2;
  localparam int SMOKE = 1;
  localparam int HUM   = 0;

  localparam int TS_W_DEF = 16;
  localparam int REC_W    = TS_W_DEF + 5;

  function automatic int rec_w(input int ts_w);
    return ts_w + 5;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] f);
    return {1'b0, f[TEMP]} + {1'b0, f[SMOKE]} + {1'b0, f[HUM]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  // Head is forced to zero when empty so the stream data is clean after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fire_event_gateway_rx.sv
// rtl/fire_event_gateway_rx.sv - vote/sensor receiver that confirms, timestamps and queues fire events
module fire_event_gateway_rx
  import fire_gw_pkg::*;
#(
  parameter int MIN_HOLD = 4,
  parameter int TS_W     = 16,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      evt_out,
  input  logic [2:0]                evt_flag,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [TS_W+4:0]           m_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [CNT_W-1:0]          glitch_cnt
);

  localparam int RW = rec_w(TS_W);
  localparam int HW = $clog2(MIN_HOLD + 1);

  logic            v_s1, v;
  logic [2:0]      f_s1, f, fp;
  logic [TS_W-1:0] timestamp;

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [TS_W-1:0] ts_start, ts_start_n;
  logic [2:0]      flag_acc, acc_n;

  logic            push;
  logic [RW-1:0]   push_rec;
  logic            glitch_inc;
  logic            full;
  logic            empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s1      <= 1'b0;
      v         <= 1'b0;
      f_s1      <= '0;
      f         <= '0;
      fp        <= '0;
      timestamp <= '0;
      state     <= IDLE;
      hold_cnt  <= '0;
      ts_start  <= '0;
      flag_acc  <= '0;
    end else begin
      v_s1      <= evt_out;
      v         <= v_s1;
      f_s1      <= evt_flag;
      f         <= f_s1;
      fp        <= f;
      timestamp <= timestamp + 1'b1;
      state     <= state_n;
      hold_cnt  <= hold_n;
      ts_start  <= ts_start_n;
      flag_acc  <= acc_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_n     = hold_cnt;
    ts_start_n = ts_start;
    acc_n      = flag_acc;
    push       = 1'b0;
    push_rec   = '0;
    glitch_inc = 1'b0;
    case (state)
      IDLE: begin
        if (v) begin
          hold_n     = HW'(1);
          ts_start_n = timestamp;
          acc_n      = f;
          // A one-cycle hold is already satisfied by the cycle that saw the vote.
          if (MIN_HOLD == 1) begin
            push     = 1'b1;
            push_rec = {FIRE, f, timestamp};
            state_n  = ACTIVE;
          end else begin
            state_n  = CONFIRM;
          end
        end else if (popcount3(f) == 2'd1 && fp == 3'b000) begin
          push     = 1'b1;
          push_rec = {FAULT, f, timestamp};
        end
      end
      CONFIRM: begin
        acc_n = flag_acc | f;
        if (!v) begin
          push       = 1'b1;
          push_rec   = {GLITCH, flag_acc, ts_start};
          glitch_inc = 1'b1;
          state_n    = IDLE;
        end else if (hold_cnt == HW'(MIN_HOLD - 1)) begin
          push     = 1'b1;
          push_rec = {FIRE, flag_acc | f, ts_start};
          state_n  = ACTIVE;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (!v) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Full is sampled before any same-cycle pop, so a concurrent pop cannot rescue the record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (push && full && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (glitch_inc && glitch_cnt != '1) begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end
    end
  end

  assign m_valid = !empty;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .full      (full),
    .pop       (m_valid && m_ready),
    .pop_data  (m_data),
    .empty     (empty),
    .count     (fifo_count)
  );

endmodule
